complex_array_addsub_stream: RTL and testbench

Parametrised successor to the fixed-size complex array add/sub unit. Holds two on-chip arrays A and B of complex samples (real/imag, signed). On start it walks elements 0..len-1 and computes a selectable complex add/sub mode per element. Results stream out through a valid/ready handshake with backpressure, followed by a done pulse. Sits between the sample loader and the downstream complex ALU stages.

---
 rtl/complex_array_addsub_stream.sv | 205 ++++++++++++++++++++
 tb/tb_complex_array_addsub_stream.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_array_addsub_stream.sv
// Two on-chip complex sample arrays A/B; on start, streams per-element add/sub results over valid/ready.
// Define CALU_SAT_EN to clamp results to W bits and expose a sticky sat_flag output.
module complex_array_addsub_stream #(
    parameter int W     = 16,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_re,
    input  logic [W-1:0]  wr_im,
    output logic          wr_err,
    input  logic          start,
    input  logic [1:0]    operation,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W:0]    res_re,
    output logic [W:0]    res_im,
    output logic [AW-1:0] res_idx,
    output logic          done
`ifdef CALU_SAT_EN
    ,
    output logic          sat_flag
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t          state_reg, state_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [1:0]      op_reg, op_next;
    logic [AW:0]     len_reg, len_next;
    logic            s1_valid_reg;
    logic [AW-1:0]   s1_idx_reg;
    logic            res_valid_reg;
    logic [W:0]      res_re_reg, res_im_reg;
    logic [AW-1:0]   res_idx_reg;
    logic            wr_err_reg;

    logic            advance, issue, last_issue, mem_we;
    logic [AW:0]     len_clamped, len_cur;
    logic signed [W:0] ar, ai, br, bi, sum_re, sum_im, out_re, out_im;

    assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
    assign len_cur     = (state_reg == S_IDLE) ? len_clamped : len_reg;
    assign last_issue  = ({1'b0, rd_ptr_reg} == (len_cur - 1'b1));
    // Stage 1 and the read pointer only move when the output register can take a new result.
    assign advance     = ~(res_valid_reg & ~res_ready);
    assign mem_we      = wr_en & (state_reg == S_IDLE);

    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign res_valid = res_valid_reg;
    assign res_re    = res_re_reg;
    assign res_im    = res_im_reg;
    assign res_idx   = res_idx_reg;
    assign wr_err    = wr_err_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [2*W-1:0] mem [DEPTH];
            logic [2*W-1:0] rd_q;
            logic           bank_we;

            assign bank_we = mem_we & (wr_sel == 1'(gi));

            always_ff @(posedge clk) begin
                if (bank_we) begin
                    mem[wr_addr] <= {wr_re, wr_im};
                end
            end

            always_ff @(posedge clk) begin
                if (issue) begin
                    rd_q <= mem[rd_ptr_reg];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        rd_ptr_next = rd_ptr_reg;
        op_next     = op_reg;
        len_next    = len_reg;
        issue       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    op_next  = operation;
                    len_next = len_clamped;
                    if (len_clamped == '0) begin
                        state_next = S_DONE;
                    end else begin
                        // Element 0 is read in the start cycle itself.
                        issue      = 1'b1;
                        state_next = last_issue ? S_DRAIN : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (advance) begin
                    issue = 1'b1;
                    if (last_issue) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!s1_valid_reg && (!res_valid_reg || res_ready)) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (issue) begin
            rd_ptr_next = last_issue ? '0 : rd_ptr_reg + 1'b1;
        end
    end

    always_comb begin
        ar = {g_bank[0].rd_q[2*W-1], g_bank[0].rd_q[2*W-1:W]};
        ai = {g_bank[0].rd_q[W-1],   g_bank[0].rd_q[W-1:0]};
        br = {g_bank[1].rd_q[2*W-1], g_bank[1].rd_q[2*W-1:W]};
        bi = {g_bank[1].rd_q[W-1],   g_bank[1].rd_q[W-1:0]};
        case (op_reg)
            2'b00:   begin sum_re = ar + br; sum_im = ai + bi; end
            2'b01:   begin sum_re = ar - br; sum_im = ai - bi; end
            2'b10:   begin sum_re = br - ar; sum_im = bi - ai; end
            default: begin sum_re = ar + br; sum_im = ai - bi; end
        endcase
    end

`ifdef CALU_SAT_EN
    localparam logic signed [W:0] MAX_V = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] MIN_V = {2'b11, {(W-1){1'b0}}};

    logic ovf_re, ovf_im, sat_hit, sat_flag_reg;

    // A W+1-bit value fits W bits exactly when its top two bits agree.
    assign ovf_re  = sum_re[W] ^ sum_re[W-1];
    assign ovf_im  = sum_im[W] ^ sum_im[W-1];
    assign sat_hit = ovf_re | ovf_im;
    assign out_re  = ovf_re ? (sum_re[W] ? MIN_V : MAX_V) : sum_re;
    assign out_im  = ovf_im ? (sum_im[W] ? MIN_V : MAX_V) : sum_im;
    assign sat_flag = sat_flag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag_reg <= 1'b0;
        end else if (state_reg == S_IDLE && start) begin
            sat_flag_reg <= 1'b0;
        end else if (advance && s1_valid_reg && sat_hit) begin
            sat_flag_reg <= 1'b1;
        end
    end
`else
    assign out_re = sum_re;
    assign out_im = sum_im;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            rd_ptr_reg    <= '0;
            op_reg        <= '0;
            len_reg       <= '0;
            s1_valid_reg  <= 1'b0;
            s1_idx_reg    <= '0;
            res_valid_reg <= 1'b0;
            res_re_reg    <= '0;
            res_im_reg    <= '0;
            res_idx_reg   <= '0;
            wr_err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rd_ptr_reg <= rd_ptr_next;
            op_reg     <= op_next;
            len_reg    <= len_next;
            wr_err_reg <= wr_en & busy;
            if (advance) begin
                s1_valid_reg  <= issue;
                res_valid_reg <= s1_valid_reg;
                if (issue) begin
                    s1_idx_reg <= rd_ptr_reg;
                end
                if (s1_valid_reg) begin
                    res_re_reg  <= out_re;
                    res_im_reg  <= out_im;
                    res_idx_reg <= s1_idx_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_complex_array_addsub_stream.sv
// Directed bench for complex_array_addsub_stream with a result scoreboard.
// Build with CALU_SAT_EN defined to exercise the saturating variant.
module tb_complex_array_addsub_stream;
    localparam int W = 16;
    localparam int DEPTH = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_re = '0;
    logic [W-1:0]  wr_im = '0;
    logic          wr_err;
    logic          start = 1'b0;
    logic [1:0]    operation = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [W:0]    res_re;
    logic [W:0]    res_im;
    logic [AW-1:0] res_idx;
    logic          done;
`ifdef CALU_SAT_EN
    logic          sat_flag;
`endif

    complex_array_addsub_stream #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_re(wr_re), .wr_im(wr_im), .wr_err(wr_err),
        .start(start), .operation(operation), .len(len),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_re(res_re), .res_im(res_im), .res_idx(res_idx),
        .done(done)
`ifdef CALU_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int re;
        int im;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;
    time  last_xfer = 0;
    int   mar[DEPTH], mai[DEPTH], mbr[DEPTH], mbi[DEPTH];
    bit   pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp(input int v);
`ifdef CALU_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
`endif
        return v;
    endfunction

    function automatic void calc(input int op, input int ar, input int ai, input int br, input int bi,
                                 output int re, output int im);
        case (op)
            0:       begin re = ar + br; im = ai + bi; end
            1:       begin re = ar - br; im = ai - bi; end
            2:       begin re = br - ar; im = bi - ai; end
            default: begin re = ar + br; im = ai - bi; end
        endcase
        re = clamp(re);
        im = clamp(im);
    endfunction

    task automatic wr(input bit sel, input int addr, input int re, input int im);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_addr = AW'(addr);
        wr_re = W'(re);
        wr_im = W'(im);
        if (sel) begin
            mbr[addr] = re;
            mbi[addr] = im;
        end else begin
            mar[addr] = re;
            mai[addr] = im;
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic push_expected(input int op, input int n);
        int re, im;
        for (int k = 0; k < n; k++) begin
            calc(op, mar[k], mai[k], mbr[k], mbi[k], re, im);
            q.push_back('{k, re, im});
        end
    endtask

    // Monitor: every cycle with a valid result is compared against the scoreboard head,
    // so a stalled result must match the same entry until it is accepted.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_result: observed idx %0d with empty scoreboard", res_idx);
            end
            if (q.size() != 0) begin
                check("res_idx", 32'(res_idx), q[0].idx);
                check("res_re", 32'($signed(res_re)), q[0].re);
                check("res_im", 32'($signed(res_im)), q[0].im);
                if (res_ready) begin
                    void'(q.pop_front());
                    xfers++;
                    last_xfer = $time;
                end
            end
        end
    end

    task automatic run_op(input int op, input int ln, input bit bp, input bit disturb);
        int n;
        int cyc;
        bit got_done;
        n = (ln > DEPTH) ? DEPTH : ln;
        xfers = 0;
        push_expected(op, n);
        operation = 2'(op);
        len = (AW+1)'(ln);
        res_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        operation = ~operation;
        len = (AW+1)'(5);
        got_done = 1'b0;
        cyc = 0;
        while (!got_done && cyc < 400) begin
            res_ready = bp ? pat[cyc % 6] : 1'b1;
            if (disturb && cyc == 0) begin
                wr_en = 1'b1;
                wr_sel = 1'b0;
                wr_addr = '0;
                wr_re = W'(999);
                wr_im = W'(-999);
                start = 1'b1;
            end
            if (disturb && cyc == 1) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
            if (cyc == 0) check("valid_cycle1", 32'(res_valid), 0);
            if (cyc == 1) check("valid_cycle2", 32'(res_valid), (n > 0) ? 1 : 0);
            if (disturb && cyc == 1) check("wr_err_pulse", 32'(wr_err), 1);
            if (disturb && cyc == 2) check("wr_err_clear", 32'(wr_err), 0);
            if (done) begin
                got_done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check("done_seen", 32'(got_done), 1);
        check("xfer_count", xfers, n);
        check("scoreboard_empty", q.size(), 0);
        if (n > 0) check("done_delay", 32'(($time - last_xfer) / 10), 1);
        // A start coinciding with the done pulse must be ignored.
        start = 1'b1;
        operation = 2'(op);
        len = (AW+1)'(4);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_done", 32'(busy), 0);
        check("done_single", 32'(done), 0);
        q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(res_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wr_err", 32'(wr_err), 0);
        check("rst_re", 32'($signed(res_re)), 0);
        check("rst_im", 32'($signed(res_im)), 0);
        check("rst_idx", 32'(res_idx), 0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 4; i < DEPTH; i++) begin
            wr(1'b0, i, i * 3 - 50, 100 - i);
            wr(1'b1, i, i, -2 * i);
        end
        wr(1'b0, 0, 1, 2);    wr(1'b0, 1, 3, 4);   wr(1'b0, 2, -5, 6);  wr(1'b0, 3, 7, -8);
        wr(1'b1, 0, 10, 20);  wr(1'b1, 1, 1, 1);   wr(1'b1, 2, 5, -6);  wr(1'b1, 3, 0, 8);

        for (int op = 0; op < 4; op++) run_op(op, 4, 1'b0, 1'b0);
        run_op(0, 4, 1'b1, 1'b0);
        run_op(2, 0, 1'b0, 1'b0);
        run_op(1, 100, 1'b0, 1'b0);
        run_op(3, 4, 1'b0, 1'b1);
        run_op(0, 4, 1'b0, 1'b0);

        wr(1'b0, 0, 32767, -32768);
        wr(1'b1, 0, 32767, -32768);
        run_op(0, 1, 1'b0, 1'b0);
`ifdef CALU_SAT_EN
        check("sat_flag", 32'(sat_flag), 1);
`endif

        // Asynchronous abort in the middle of a long run.
        push_expected(0, DEPTH);
        operation = 2'b00;
        len = (AW+1)'(DEPTH);
        res_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(res_valid), 0);
        check("abort_re", 32'($signed(res_re)), 0);
        check("abort_idx", 32'(res_idx), 0);
        q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_abort_busy", 32'(busy), 0);
        check("post_abort_done", 32'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
